// File: rtl/sram_arb_pkg.sv
// Shared types for the two-client SRAM arbiter: FSM states, client ids and the
// round-robin winner selection.
package sram_arb_pkg;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} arb_state_t;
    typedef enum logic {CLIENT_A, CLIENT_B} client_t;

    // On contention the client that did not win last time goes first.
    function automatic client_t pick_winner(input logic    req_a,
                                            input logic    req_b,
                                            input client_t last_grant);
        if (req_a && req_b) begin
            return (last_grant == CLIENT_A) ? CLIENT_B : CLIENT_A;
        end else if (req_a) begin
            return CLIENT_A;
        end
        return CLIENT_B;
    endfunction

endpackage

// File: rtl/sram_arbiter.sv
// Round-robin arbiter that serialises single-byte SRAM reads/writes from the
// I2C receive path (A) and the Triple-DES engine (B); all outputs registered.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W        = 16,
    parameter int DATA_W        = 8,
    parameter int ACCESS_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_a,
    input  logic              rw_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] wdata_a,
    output logic              ack_a,
    input  logic              req_b,
    input  logic              rw_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata_b,
    output logic              ack_b,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] sram_address,
    output logic              sram_read_en,
    output logic              sram_write_en,
    output logic [DATA_W-1:0] sram_write_data,
    input  logic [DATA_W-1:0] sram_read_data
);

    localparam int CNT_W = $clog2(ACCESS_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);

    arb_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    client_t           client_q, client_d;
    client_t           last_grant_q, last_grant_d;
    logic              rw_q, rw_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              read_en_q, read_en_d;
    logic              write_en_q, write_en_d;
    logic              ack_a_q, ack_a_d;
    logic              ack_b_q, ack_b_d;
    client_t           winner;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        client_d     = client_q;
        last_grant_d = last_grant_q;
        rw_d         = rw_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        read_en_d    = read_en_q;
        write_en_d   = write_en_q;
        ack_a_d      = 1'b0;
        ack_b_d      = 1'b0;
        winner       = pick_winner(req_a, req_b, last_grant_q);

        case (state_q)
            IDLE: begin
                if (req_a || req_b) begin
                    // The latched address/data register doubles as the SRAM drive.
                    client_d     = winner;
                    last_grant_d = winner;
                    rw_d         = (winner == CLIENT_A) ? rw_a    : rw_b;
                    addr_d       = (winner == CLIENT_A) ? addr_a  : addr_b;
                    wdata_d      = (winner == CLIENT_A) ? wdata_a : wdata_b;
                    write_en_d   = rw_d;
                    read_en_d    = !rw_d;
                    cnt_d        = '0;
                    state_d      = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == CNT_LAST) begin
                    if (!rw_q) begin
                        rdata_d = sram_read_data;
                    end
                    write_en_d = 1'b0;
                    read_en_d  = 1'b0;
                    ack_a_d    = (client_q == CLIENT_A);
                    ack_b_d    = (client_q == CLIENT_B);
                    state_d    = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d    = IDLE;
                write_en_d = 1'b0;
                read_en_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            client_q     <= CLIENT_A;
            last_grant_q <= CLIENT_B;
            rw_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            read_en_q    <= 1'b0;
            write_en_q   <= 1'b0;
            ack_a_q      <= 1'b0;
            ack_b_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            client_q     <= client_d;
            last_grant_q <= last_grant_d;
            rw_q         <= rw_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            read_en_q    <= read_en_d;
            write_en_q   <= write_en_d;
            ack_a_q      <= ack_a_d;
            ack_b_q      <= ack_b_d;
        end
    end

    assign ack_a           = ack_a_q;
    assign ack_b           = ack_b_q;
    assign rdata           = rdata_q;
    assign sram_address    = addr_q;
    assign sram_write_data = wdata_q;
    assign sram_read_en    = read_en_q;
    assign sram_write_en   = write_en_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: table of arbitration rounds plus hand sequences, with a
// reference memory feeding an expected-access queue checked by a bus monitor.
module tb_sram_arbiter;
    import sram_arb_pkg::*;

    localparam int AC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_a, rw_a, req_b, rw_b;
    logic [15:0] addr_a, addr_b;
    logic [7:0]  wdata_a, wdata_b;
    logic        ack_a, ack_b;
    logic [7:0]  rdata;
    logic [15:0] sram_address;
    logic        sram_read_en, sram_write_en;
    logic [7:0]  sram_write_data;
    logic [7:0]  sram_read_data;

    sram_arbiter #(.ADDR_W(16), .DATA_W(8), .ACCESS_CYCLES(AC)) dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .rw_a(rw_a), .addr_a(addr_a), .wdata_a(wdata_a), .ack_a(ack_a),
        .req_b(req_b), .rw_b(rw_b), .addr_b(addr_b), .wdata_b(wdata_b), .ack_b(ack_b),
        .rdata(rdata), .sram_address(sram_address), .sram_read_en(sram_read_en),
        .sram_write_en(sram_write_en), .sram_write_data(sram_write_data),
        .sram_read_data(sram_read_data)
    );

    always #5 clk = ~clk;

    // Synchronous SRAM: one-cycle read latency.
    logic [7:0] mem [0:65535];
    always @(posedge clk) begin
        if (sram_write_en) mem[sram_address] <= sram_write_data;
        if (sram_read_en)  sram_read_data    <= mem[sram_address];
    end

    typedef struct {
        logic        ra;  logic rwa; logic [15:0] aa; logic [7:0] da;
        logic        rb;  logic rwb; logic [15:0] ab; logic [7:0] db;
        client_t     exp;
    } vec_t;

    typedef struct {
        client_t     c;
        logic        rw;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  rdata;
    } exp_t;

    vec_t       vecs[$];
    exp_t       sb[$];
    logic [7:0] ref_mem [0:65535];
    logic [7:0] ref_rdata;
    int         n_vec = 0;
    int         n_err = 0;
    int         en_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic push_exp(input client_t c, input logic rw, input logic [15:0] addr,
                            input logic [7:0] wdata);
        exp_t e;
        if (rw) ref_mem[addr] = wdata;
        else    ref_rdata     = ref_mem[addr];
        e.c = c; e.rw = rw; e.addr = addr; e.wdata = wdata; e.rdata = ref_rdata;
        sb.push_back(e);
    endtask

    task automatic wait_ack();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(ack_a || ack_b) && n < 20);
        if (!(ack_a || ack_b)) begin
            n_vec++; n_err++;
            $display("FAIL ack_timeout: no ack after %0d cycles, expected one", n);
        end
    endtask

    task automatic wait_enable();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(sram_read_en || sram_write_en) && n < 20);
        if (!(sram_read_en || sram_write_en)) begin
            n_vec++; n_err++;
            $display("FAIL en_timeout: no enable after %0d cycles, expected one", n);
        end
    endtask

    // Bus monitor: every enabled cycle and every ack is checked against the queue head.
    always @(negedge clk) begin
        if (!rst) begin
            chk("en_exclusive", {31'b0, sram_read_en && sram_write_en}, 32'd0);
            if (sram_read_en || sram_write_en) begin
                if (sb.size() == 0) begin
                    chk("unexpected_enable", {31'b0, sram_read_en || sram_write_en}, 32'd0);
                end else begin
                    en_cnt++;
                    chk("sram_address", {16'b0, sram_address}, {16'b0, sb[0].addr});
                    chk("en_direction", {31'b0, sram_write_en}, {31'b0, sb[0].rw});
                    if (sb[0].rw) chk("sram_write_data", {24'b0, sram_write_data}, {24'b0, sb[0].wdata});
                end
            end
            if (ack_a || ack_b) begin
                chk("ack_exclusive", {31'b0, ack_a && ack_b}, 32'd0);
                if (sb.size() == 0) begin
                    chk("unexpected_ack", {30'b0, ack_b, ack_a}, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("grant_client", {31'b0, ack_b}, {31'b0, e.c == CLIENT_B});
                    chk("enable_cycles", en_cnt, AC);
                    chk("rdata", {24'b0, rdata}, {24'b0, e.rdata});
                end
                en_cnt = 0;
            end
        end
    end

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem[i]     = 8'h00;
            ref_mem[i] = 8'h00;
        end
        ref_rdata = 8'h00;
        rst = 1'b1;
        req_a = 0; rw_a = 0; addr_a = '0; wdata_a = '0;
        req_b = 0; rw_b = 0; addr_b = '0; wdata_b = '0;

        //            ra rwa aa       da     rb rwb ab       db     winner
        vecs.push_back('{1, 1, 16'h0010, 8'hA5, 1, 0, 16'h0010, 8'h00, CLIENT_A});
        vecs.push_back('{0, 0, 16'h0000, 8'h00, 1, 0, 16'h0010, 8'h00, CLIENT_B});
        vecs.push_back('{1, 1, 16'h0100, 8'h11, 1, 0, 16'h0100, 8'h00, CLIENT_A});
        vecs.push_back('{1, 1, 16'h0101, 8'h22, 1, 0, 16'h0100, 8'h00, CLIENT_B});
        vecs.push_back('{1, 1, 16'h0102, 8'h33, 1, 0, 16'h0101, 8'h00, CLIENT_A});
        vecs.push_back('{1, 1, 16'h0103, 8'h44, 1, 0, 16'h0102, 8'h00, CLIENT_B});
        vecs.push_back('{1, 1, 16'h0104, 8'h55, 1, 0, 16'h0103, 8'h00, CLIENT_A});
        vecs.push_back('{1, 1, 16'h0105, 8'h66, 1, 0, 16'h0104, 8'h00, CLIENT_B});
        vecs.push_back('{1, 0, 16'h0101, 8'h00, 0, 0, 16'h0000, 8'h00, CLIENT_A});
        vecs.push_back('{0, 0, 16'h0000, 8'h00, 1, 1, 16'h0200, 8'hC3, CLIENT_B});
        vecs.push_back('{1, 0, 16'h0200, 8'h00, 1, 1, 16'h0201, 8'h3C, CLIENT_A});
        vecs.push_back('{0, 0, 16'h0000, 8'h00, 1, 1, 16'h0201, 8'h3C, CLIENT_B});
        vecs.push_back('{1, 0, 16'h00FF, 8'h00, 0, 0, 16'h0000, 8'h00, CLIENT_A});

        repeat (2) @(negedge clk);
        chk("rst_ack_a", {31'b0, ack_a}, 32'd0);
        chk("rst_ack_b", {31'b0, ack_b}, 32'd0);
        chk("rst_read_en", {31'b0, sram_read_en}, 32'd0);
        chk("rst_write_en", {31'b0, sram_write_en}, 32'd0);
        chk("rst_address", {16'b0, sram_address}, 32'd0);
        chk("rst_write_data", {24'b0, sram_write_data}, 32'd0);
        chk("rst_rdata", {24'b0, rdata}, 32'd0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            req_a = vecs[i].ra; rw_a = vecs[i].rwa; addr_a = vecs[i].aa; wdata_a = vecs[i].da;
            req_b = vecs[i].rb; rw_b = vecs[i].rwb; addr_b = vecs[i].ab; wdata_b = vecs[i].db;
            if (vecs[i].exp == CLIENT_A) push_exp(CLIENT_A, vecs[i].rwa, vecs[i].aa, vecs[i].da);
            else                         push_exp(CLIENT_B, vecs[i].rwb, vecs[i].ab, vecs[i].db);
            wait_ack();
        end
        req_a = 0; req_b = 0;
        @(negedge clk);
        chk("ack_pulse_a", {31'b0, ack_a}, 32'd0);
        chk("ack_pulse_b", {31'b0, ack_b}, 32'd0);

        // Address/data/direction changes after the grant must not reach the SRAM.
        req_a = 1; rw_a = 1; addr_a = 16'h0020; wdata_a = 8'h5A;
        push_exp(CLIENT_A, 1'b1, 16'h0020, 8'h5A);
        wait_enable();
        addr_a = 16'h0030; wdata_a = 8'hFF; rw_a = 0;
        wait_ack();
        req_a = 0;
        req_b = 1; rw_b = 0; addr_b = 16'h0030;
        push_exp(CLIENT_B, 1'b0, 16'h0030, 8'h00);
        wait_ack();
        // Dropping req mid-access still completes with an ack.
        addr_b = 16'h0020;
        push_exp(CLIENT_B, 1'b0, 16'h0020, 8'h00);
        wait_enable();
        req_b = 0;
        wait_ack();

        // Reset during the first enabled cycle abandons the access.
        @(negedge clk);
        req_a = 1; rw_a = 0; addr_a = 16'h0010;
        push_exp(CLIENT_A, 1'b0, 16'h0010, 8'h00);
        wait_enable();
        rst = 1; req_a = 0;
        @(negedge clk);
        rst = 0;
        sb.delete();
        en_cnt = 0;
        ref_rdata = 8'h00;
        chk("abort_read_en", {31'b0, sram_read_en}, 32'd0);
        chk("abort_write_en", {31'b0, sram_write_en}, 32'd0);
        chk("abort_rdata", {24'b0, rdata}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_no_ack", {30'b0, ack_b, ack_a}, 32'd0);
        end
        req_a = 1; rw_a = 1; addr_a = 16'h0040; wdata_a = 8'h77;
        push_exp(CLIENT_A, 1'b1, 16'h0040, 8'h77);
        wait_ack();
        req_a = 0;
        req_b = 1; rw_b = 0; addr_b = 16'h0040;
        push_exp(CLIENT_B, 1'b0, 16'h0040, 8'h00);
        wait_ack();
        req_b = 0;
        repeat (3) @(negedge clk);
        chk("queue_drained", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
